// File: rtl/display_timing_gen.sv
// display_timing_gen
//   Raster timing generator (default 640x480@60 Hz from a 100 MHz clock).
//   Produces a pixel-rate enable, horizontal/vertical position counters,
//   active-low sync pulses, the active-video flag, a per-frame strobe and a
//   frame-divided game tick used as the motion "slow clock" enable.
// Ports:
//   clk        in   board clock
//   rst        in   synchronous active-high reset
//   pix_en     out  one-clk pulse every CLK_DIV clocks
//   hCount     out  [9:0] column 0..H_TOTAL-1
//   vCount     out  [9:0] line   0..V_TOTAL-1
//   hSync      out  active-low, low while hCount < H_SYNC
//   vSync      out  active-low, low while vCount < V_SYNC
//   bright     out  high inside the active window
//   frame_tick out  one-clk pulse when counters wrap to (0,0)
//   game_tick  out  one-clk pulse on every FRAME_DIV-th frame_tick
module display_timing_gen #(
  parameter int CLK_DIV   = 4,
  parameter int H_TOTAL   = 800,
  parameter int H_SYNC    = 96,
  parameter int H_START   = 144,
  parameter int H_ACTIVE  = 640,
  parameter int V_TOTAL   = 525,
  parameter int V_SYNC    = 2,
  parameter int V_START   = 35,
  parameter int V_ACTIVE  = 480,
  parameter int FRAME_DIV = 2
) (
  input  logic       clk,
  input  logic       rst,
  output logic       pix_en,
  output logic [9:0] hCount,
  output logic [9:0] vCount,
  output logic       hSync,
  output logic       vSync,
  output logic       bright,
  output logic       frame_tick,
  output logic       game_tick
);

  localparam int DW = (CLK_DIV   > 1) ? $clog2(CLK_DIV)   : 1;
  localparam int FW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [FW-1:0] FR_LAST  = FW'(FRAME_DIV - 1);
  localparam logic [9:0]    H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]    V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]    H_SY     = 10'(H_SYNC);
  localparam logic [9:0]    V_SY     = 10'(V_SYNC);
  localparam logic [9:0]    H_ST     = 10'(H_START);
  localparam logic [9:0]    H_END    = 10'(H_START + H_ACTIVE);
  localparam logic [9:0]    V_ST     = 10'(V_START);
  localparam logic [9:0]    V_END    = 10'(V_START + V_ACTIVE);

  logic [DW-1:0] r_div;
  logic [FW-1:0] r_fcnt;

  logic       w_h_last, w_v_last, w_line_wrap, w_frame_wrap;
  logic [9:0] w_h_nxt, w_v_nxt;

  // Next-count values feed both the counter registers and the decode
  // registers, so sync/bright always line up with the counts shown.
  always_comb begin
    w_h_last     = (hCount == H_LAST);
    w_v_last     = (vCount == V_LAST);
    w_line_wrap  = pix_en & w_h_last;
    w_frame_wrap = w_line_wrap & w_v_last;
    w_h_nxt      = hCount;
    w_v_nxt      = vCount;
    if (pix_en)
      w_h_nxt = w_h_last ? 10'd0 : hCount + 10'd1;
    if (w_line_wrap)
      w_v_nxt = w_v_last ? 10'd0 : vCount + 10'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_div      <= '0;
      r_fcnt     <= '0;
      pix_en     <= 1'b0;
      hCount     <= '0;
      vCount     <= '0;
      hSync      <= 1'b0;
      vSync      <= 1'b0;
      bright     <= 1'b0;
      frame_tick <= 1'b0;
      game_tick  <= 1'b0;
    end else begin
      r_div  <= (r_div == DIV_LAST) ? '0 : r_div + DW'(1);
      // Registered terminal-count decode: high for exactly one clk per wrap.
      pix_en <= (r_div == DIV_LAST);

      hCount <= w_h_nxt;
      vCount <= w_v_nxt;
      hSync  <= ~(w_h_nxt < H_SY);
      vSync  <= ~(w_v_nxt < V_SY);
      bright <= (w_h_nxt >= H_ST) && (w_h_nxt < H_END) &&
                (w_v_nxt >= V_ST) && (w_v_nxt < V_END);

      frame_tick <= w_frame_wrap;
      game_tick  <= 1'b0;
      if (w_frame_wrap) begin
        if (r_fcnt == FR_LAST) begin
          r_fcnt    <= '0;
          game_tick <= 1'b1;
        end else begin
          r_fcnt <= r_fcnt + FW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_display_timing_gen.sv
// Testbench for display_timing_gen. Uses a shrunken raster so many frames
// fit in a short run; two instances differ only in FRAME_DIV (2 and 1).
// The reference model derives every output from the number of clocks
// elapsed since reset using plain division/modulo arithmetic.
module tb_display_timing_gen;

  localparam int CD = 4;
  localparam int HT = 20, HS = 3, HB = 5, HA = 12;
  localparam int VT = 10, VS = 2, VB = 3, VA = 5;
  localparam int FRAME_CLKS = CD * HT * VT;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       pe_a, hs_a, vs_a, br_a, ft_a, gt_a;
  logic [9:0] hc_a, vc_a;
  logic       pe_b, hs_b, vs_b, br_b, ft_b, gt_b;
  logic [9:0] hc_b, vc_b;

  display_timing_gen #(
    .CLK_DIV(CD), .H_TOTAL(HT), .H_SYNC(HS), .H_START(HB), .H_ACTIVE(HA),
    .V_TOTAL(VT), .V_SYNC(VS), .V_START(VB), .V_ACTIVE(VA), .FRAME_DIV(2)
  ) u_a (
    .clk(clk), .rst(rst), .pix_en(pe_a), .hCount(hc_a), .vCount(vc_a),
    .hSync(hs_a), .vSync(vs_a), .bright(br_a), .frame_tick(ft_a),
    .game_tick(gt_a)
  );

  display_timing_gen #(
    .CLK_DIV(CD), .H_TOTAL(HT), .H_SYNC(HS), .H_START(HB), .H_ACTIVE(HA),
    .V_TOTAL(VT), .V_SYNC(VS), .V_START(VB), .V_ACTIVE(VA), .FRAME_DIV(1)
  ) u_b (
    .clk(clk), .rst(rst), .pix_en(pe_b), .hCount(hc_b), .vCount(vc_b),
    .hSync(hs_b), .vSync(vs_b), .bright(br_b), .frame_tick(ft_b),
    .game_tick(gt_b)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int unsigned t = 0;      // clocks since the last edge that sampled rst high
  int unsigned cyc = 0;
  int last_ft = -1;
  int bcnt = 0;
  bit bvalid = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s t=%0d observed=%h expected=%h", tag, t, obs, exp);
    end
  endtask

  // Expected output vector {pix_en,hCount,vCount,hSync,vSync,bright,ft,gt}.
  function automatic logic [25:0] model(input int unsigned tt, input int fd);
    int unsigned n, h, v, fr;
    logic pe, hs, vs, br, ft, gt;
    n  = (tt == 0) ? 0 : (tt - 1) / CD;   // pixel increments applied so far
    h  = n % HT;
    v  = (n / HT) % VT;
    fr = n / (HT * VT);
    pe = (tt > 0) && (tt % CD == 0);
    hs = !(h < HS);
    vs = !(v < VS);
    br = (h >= HB) && (h < HB + HA) && (v >= VB) && (v < VB + VA);
    ft = (tt > CD) && ((tt - 1) % CD == 0) && (n % (HT * VT) == 0);
    gt = ft && (fr % fd == 0);
    return {pe, 10'(h), 10'(v), hs, vs, br, ft, gt};
  endfunction

  // One clock: update model, compare both instances, then set rst for the
  // next edge.
  task automatic step(input bit rst_next);
    @(posedge clk);
    #1;
    cyc++;
    if (rst) begin
      t = 0; last_ft = -1; bvalid = 1'b0; bcnt = 0;
    end else begin
      t++;
    end
    chk("outs_fd2", {6'd0, pe_a, hc_a, vc_a, hs_a, vs_a, br_a, ft_a, gt_a},
        {6'd0, model(t, 2)});
    chk("outs_fd1", {6'd0, pe_b, hc_b, vc_b, hs_b, vs_b, br_b, ft_b, gt_b},
        {6'd0, model(t, 1)});
    if (!rst && ft_a) begin
      if (last_ft >= 0) chk("frame_period", cyc - last_ft, FRAME_CLKS);
      if (bvalid) chk("bright_pixels", bcnt, HA * VA);
      last_ft = cyc; bvalid = 1'b1; bcnt = 0;
    end
    if (pe_a && br_a) bcnt++;
    rst = rst_next;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0);
  endtask

  task automatic hold_rst(input int n);
    for (int i = 0; i < n - 1; i++) step(1'b1);
    step(1'b0);
  endtask

  initial begin
    rst = 1'b1;
    hold_rst(3);
    run(2 * FRAME_CLKS + 500);   // mid-frame
    rst = 1'b1;
    hold_rst(5);
    run(4 * FRAME_CLKS + 150);
    for (int k = 0; k < 4; k++) begin
      rst = 1'b1;
      hold_rst($urandom_range(1, 3));
      run($urandom_range(50, 900));
    end
    run(2 * FRAME_CLKS);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
